// File: rtl/dispatch_allocator.sv
// Dispatch allocator: checks ROB/LDQ/STQ capacity for each decoded instruction,
// allocates tail entries and emits a registered dispatch with the assigned tags.

module dispatch_queue_ptr #(
    parameter int unsigned SIZE = 8,
    localparam int unsigned W = $clog2(SIZE)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         alloc,
    input  logic         commit,
    input  logic         flush,
    output logic [W-1:0] tail_q,
    output logic [W:0]   count_q,
    output logic         full
);
    localparam logic [W-1:0] LAST = W'(SIZE - 1);

    logic [W-1:0] head_q, head_d, tail_d;
    logic [W:0]   count_d;
    logic         commit_ok;

    function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] p);
        return (p == LAST) ? '0 : p + W'(1);
    endfunction

    assign full      = (count_q == (W+1)'(SIZE));
    assign commit_ok = commit && (count_q != '0);

    // Commits still retire during a flush; the flush then collapses tail onto the new head.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (commit_ok) begin
            head_d = wrap_inc(head_q);
        end
        if (flush) begin
            tail_d  = head_d;
            count_d = '0;
        end else begin
            if (alloc) begin
                tail_d = wrap_inc(tail_q);
            end
            count_d = count_q + (W+1)'(alloc) - (W+1)'(commit_ok);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

module dispatch_allocator #(
    parameter int unsigned ROB_SIZE = 16,
    parameter int unsigned LDQ_SIZE = 8,
    parameter int unsigned STQ_SIZE = 8,
    localparam int unsigned RW = $clog2(ROB_SIZE),
    localparam int unsigned LW = $clog2(LDQ_SIZE),
    localparam int unsigned SW = $clog2(STQ_SIZE)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          dec_valid,
    input  logic          dec_alloc_rob,
    input  logic          dec_alloc_ldq,
    input  logic          dec_alloc_stq,
    output logic          dec_ready,
    input  logic          rob_commit,
    input  logic          ldq_commit,
    input  logic          stq_commit,
    input  logic          flush,
    output logic          dispatch_valid,
    output logic [RW-1:0] dispatch_rob_tag,
    output logic [LW-1:0] dispatch_ldq_index,
    output logic [SW-1:0] dispatch_stq_index,
    output logic          dispatch_ldq,
    output logic          dispatch_stq,
    output logic [RW:0]   rob_count,
    output logic [LW:0]   ldq_count,
    output logic [SW:0]   stq_count
);
    logic [RW-1:0] rob_tail;
    logic [LW-1:0] ldq_tail;
    logic [SW-1:0] stq_tail;
    logic          rob_full, ldq_full, stq_full;
    logic          accept;

    // Capacity check uses registered counts only; same-cycle commits do not bypass.
    assign dec_ready = !flush && !(dec_alloc_rob && rob_full)
                     && !(dec_alloc_ldq && ldq_full) && !(dec_alloc_stq && stq_full);
    assign accept    = dec_valid && dec_ready;

    dispatch_queue_ptr #(.SIZE(ROB_SIZE)) u_rob (
        .clk(clk), .reset_n(reset_n), .alloc(accept && dec_alloc_rob), .commit(rob_commit),
        .flush(flush), .tail_q(rob_tail), .count_q(rob_count), .full(rob_full)
    );

    dispatch_queue_ptr #(.SIZE(LDQ_SIZE)) u_ldq (
        .clk(clk), .reset_n(reset_n), .alloc(accept && dec_alloc_ldq), .commit(ldq_commit),
        .flush(flush), .tail_q(ldq_tail), .count_q(ldq_count), .full(ldq_full)
    );

    dispatch_queue_ptr #(.SIZE(STQ_SIZE)) u_stq (
        .clk(clk), .reset_n(reset_n), .alloc(accept && dec_alloc_stq), .commit(stq_commit),
        .flush(flush), .tail_q(stq_tail), .count_q(stq_count), .full(stq_full)
    );

    // Index registers capture the tail only for the queues the instruction uses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dispatch_valid     <= 1'b0;
            dispatch_ldq       <= 1'b0;
            dispatch_stq       <= 1'b0;
            dispatch_rob_tag   <= '0;
            dispatch_ldq_index <= '0;
            dispatch_stq_index <= '0;
        end else begin
            dispatch_valid <= accept;
            dispatch_ldq   <= accept && dec_alloc_ldq;
            dispatch_stq   <= accept && dec_alloc_stq;
            if (accept && dec_alloc_rob) begin
                dispatch_rob_tag <= rob_tail;
            end
            if (accept && dec_alloc_ldq) begin
                dispatch_ldq_index <= ldq_tail;
            end
            if (accept && dec_alloc_stq) begin
                dispatch_stq_index <= stq_tail;
            end
        end
    end
endmodule

// File: tb/tb_dispatch_allocator.sv
// Directed testbench for dispatch_allocator with ROB=16, LDQ=8, STQ=8.

module tb_dispatch_allocator;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       dec_valid, dec_alloc_rob, dec_alloc_ldq, dec_alloc_stq;
    logic       dec_ready;
    logic       rob_commit, ldq_commit, stq_commit, flush;
    logic       dispatch_valid;
    logic [3:0] dispatch_rob_tag;
    logic [2:0] dispatch_ldq_index;
    logic [2:0] dispatch_stq_index;
    logic       dispatch_ldq, dispatch_stq;
    logic [4:0] rob_count;
    logic [3:0] ldq_count;
    logic [3:0] stq_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dispatch_allocator dut (
        .clk(clk), .reset_n(reset_n),
        .dec_valid(dec_valid), .dec_alloc_rob(dec_alloc_rob),
        .dec_alloc_ldq(dec_alloc_ldq), .dec_alloc_stq(dec_alloc_stq),
        .dec_ready(dec_ready),
        .rob_commit(rob_commit), .ldq_commit(ldq_commit), .stq_commit(stq_commit),
        .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_rob_tag(dispatch_rob_tag),
        .dispatch_ldq_index(dispatch_ldq_index), .dispatch_stq_index(dispatch_stq_index),
        .dispatch_ldq(dispatch_ldq), .dispatch_stq(dispatch_stq),
        .rob_count(rob_count), .ldq_count(ldq_count), .stq_count(stq_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic l, input logic s,
                         input logic rc, input logic lc, input logic sc, input logic fl);
        dec_valid = v; dec_alloc_rob = r; dec_alloc_ldq = l; dec_alloc_stq = s;
        rob_commit = rc; ldq_commit = lc; stq_commit = sc; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (2) tick();
        chk("rst_valid", 32'(dispatch_valid), 0);
        chk("rst_tag", 32'(dispatch_rob_tag), 0);
        chk("rst_ldq_idx", 32'(dispatch_ldq_index), 0);
        chk("rst_stq_idx", 32'(dispatch_stq_index), 0);
        chk("rst_rob_count", 32'(rob_count), 0);
        chk("rst_ldq_count", 32'(ldq_count), 0);
        chk("rst_ready", 32'(dec_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Three back-to-back ALU instructions
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            tick();
            chk("alu_valid", 32'(dispatch_valid), 1);
            chk("alu_tag", 32'(dispatch_rob_tag), 32'(i));
            chk("alu_ldq", 32'(dispatch_ldq), 0);
            chk("alu_stq", 32'(dispatch_stq), 0);
        end
        idle();
        chk("alu_rob_count", 32'(rob_count), 3);

        // Fill the LDQ with 8 loads
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 0, 0, 0, 0, 0);
            tick();
            chk("ld_idx", 32'(dispatch_ldq_index), 32'(i));
            chk("ld_tag", 32'(dispatch_rob_tag), 32'(i + 3));
            chk("ld_flag", 32'(dispatch_ldq), 1);
        end
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        chk("ldq_full_ready", 32'(dec_ready), 0);
        tick();
        chk("ldq_full_valid", 32'(dispatch_valid), 0);
        chk("ldq_full_count", 32'(ldq_count), 8);
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        chk("st_ready", 32'(dec_ready), 1);
        tick();
        chk("st_valid", 32'(dispatch_valid), 1);
        chk("st_idx", 32'(dispatch_stq_index), 0);
        chk("st_flag", 32'(dispatch_stq), 1);
        chk("st_ldq_flag", 32'(dispatch_ldq), 0);
        chk("st_tag", 32'(dispatch_rob_tag), 11);
        chk("st_count", 32'(stq_count), 1);

        // Fill the ROB, then commit while full: no bypass, then wrap
        for (int i = 12; i < 16; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            tick();
            chk("fill_tag", 32'(dispatch_rob_tag), 32'(i));
        end
        chk("rob_full_count", 32'(rob_count), 16);
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        chk("rob_full_ready", 32'(dec_ready), 0);
        tick();
        chk("rob_full_valid", 32'(dispatch_valid), 0);
        chk("rob_after_commit", 32'(rob_count), 15);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("wrap_ready", 32'(dec_ready), 1);
        tick();
        chk("wrap_tag", 32'(dispatch_rob_tag), 0);
        chk("wrap_count", 32'(rob_count), 16);

        // Flush: ROB head=1 so tail collapses to 1; LDQ/STQ collapse to head 0
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("flush_valid", 32'(dispatch_valid), 0);
        chk("flush_rob", 32'(rob_count), 0);
        chk("flush_ldq", 32'(ldq_count), 0);
        chk("flush_stq", 32'(stq_count), 0);

        for (int i = 1; i < 6; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            tick();
            chk("post_flush_tag", 32'(dispatch_rob_tag), 32'(i));
        end
        chk("count5", 32'(rob_count), 5);
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        tick();
        chk("ac_tag", 32'(dispatch_rob_tag), 6);
        chk("ac_count", 32'(rob_count), 5);

        // Flush with commit and a valid instruction: head 2 -> 3
        drive(1, 1, 0, 0, 1, 0, 0, 1);
        chk("flush_ready", 32'(dec_ready), 0);
        tick();
        chk("flc_valid", 32'(dispatch_valid), 0);
        chk("flc_count", 32'(rob_count), 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("flc_tag", 32'(dispatch_rob_tag), 3);
        chk("flc_count1", 32'(rob_count), 1);

        // Commit to empty, then commit while empty must not move head
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        chk("drain_count", 32'(rob_count), 0);
        drive(0, 0, 0, 0, 1, 1, 1, 0);
        tick();
        chk("empty_commit_rob", 32'(rob_count), 0);
        chk("empty_commit_ldq", 32'(ldq_count), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        tick();
        chk("empty_head_tag", 32'(dispatch_rob_tag), 4);
        chk("empty_head_ldq", 32'(dispatch_ldq_index), 0);
        chk("empty_head_lflag", 32'(dispatch_ldq), 1);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("ldq_commit", 32'(ldq_count), 0);
        chk("ldq_commit_rob", 32'(rob_count), 1);

        // Asynchronous reset mid-stream
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        tick();
        chk("pre_rst_tag", 32'(dispatch_rob_tag), 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(dispatch_valid), 0);
        chk("async_tag", 32'(dispatch_rob_tag), 0);
        chk("async_stq_idx", 32'(dispatch_stq_index), 0);
        chk("async_stq_flag", 32'(dispatch_stq), 0);
        chk("async_rob", 32'(rob_count), 0);
        chk("async_stq", 32'(stq_count), 0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
